alu_seq_unit: RTL and testbench

- Parametrised, sequential successor to the datapath ALU, flag flip-flops and branch decoder, merged into one block.
- Accepts one operation per start/ready handshake. Single-cycle ops finish in one clock; shifts and multiply iterate one step per clock.
- Holds an NZVC flag register and evaluates the 16 branch conditions from it.
- Sits between the register file / literal mux and the writeback mux. The core controller drives start and waits for done.

---
 rtl/alu_seq_unit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Sequential ALU with NZVC flag register and branch-condition evaluator.
// Optional multi-cycle multiply is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_we,
  input  logic             flush,
  input  logic [3:0]       cond,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             br_taken
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] MUL   = 2'd2;
`endif

  localparam logic [3:0] OP_A   = 4'd1;
  localparam logic [3:0] OP_B   = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_ASR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_ADC = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_ILL = 4'd15;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [1:0]       sh_op_q, sh_op_d;
  logic             fwe_q, fwe_d;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
`endif

  logic [WIDTH:0]   sum_add, sum_adc, sum_inc, sum_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v, alu_c;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  // Single-cycle datapath; sub/cmp carry is "no borrow" via A + ~B + 1.
  always_comb begin
    sum_add = {1'b0, a} + {1'b0, b};
    sum_adc = sum_add + {{WIDTH{1'b0}}, flags_q[0]};
    sum_inc = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (op)
      OP_A:   alu_res = a;
      OP_B:   alu_res = b;
      OP_OR:  alu_res = a | b;
      OP_AND: alu_res = a & b;
      OP_XOR: alu_res = a ^ b;
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADC: begin
        alu_res = sum_adc[WIDTH-1:0];
        alu_c   = sum_adc[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        alu_res = sum_inc[WIDTH-1:0];
        alu_c   = sum_inc[WIDTH];
        alu_v   = !a[WIDTH-1] && alu_res[WIDTH-1];
      end
      OP_SUB, OP_CMP: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
    alu_flags = {alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c};
  end

  // One-bit shift step; sh_op holds op[1:0] (01 shl, 10 shr, 11 asr).
  always_comb begin
    case (sh_op_q)
      2'b01:   sh_next = {sh_q[WIDTH-2:0], 1'b0};
      2'b10:   sh_next = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
    sh_out = (sh_op_q == 2'b01) ? sh_q[WIDTH-1] : sh_q[0];
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-add step: multiplier sits in the low half and drains out to the right.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {mul_sum, prod_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sh_op_d  = sh_op_q;
    fwe_d    = fwe_q;
`ifdef ALU_SEQ_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          fwe_d = flag_we;
          case (op)
            OP_SHL, OP_SHR, OP_ASR: begin
              if (shamt != '0) begin
                state_d = SHIFT;
                sh_d    = a;
                sh_op_d = op[1:0];
                cnt_d   = CNT_W'(shamt);
              end else begin
                done_d   = 1'b1;
                result_d = a;
                if (flag_we) flags_d = {a[WIDTH-1], a == '0, 1'b0, 1'b0};
              end
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
              state_d = MUL;
              prod_d  = {{WIDTH{1'b0}}, b};
              mcand_d = a;
              cnt_d   = CNT_W'(WIDTH);
`else
              done_d   = 1'b1;
              err_d    = 1'b1;
              result_d = '0;
`endif
            end
            OP_ILL: begin
              done_d   = 1'b1;
              err_d    = 1'b1;
              result_d = '0;
            end
            default: begin
              done_d = 1'b1;
              if (op != OP_CMP) result_d = alu_res;
              if (flag_we) flags_d = alu_flags;
            end
          endcase
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          sh_d  = sh_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = sh_next;
            if (fwe_q) flags_d = {sh_next[WIDTH-1], sh_next == '0, 1'b0, sh_out};
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          prod_d = prod_next;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = prod_next[WIDTH-1:0];
            if (fwe_q) begin
              flags_d = {prod_next[WIDTH-1], prod_next[WIDTH-1:0] == '0,
                         prod_next[2*WIDTH-1:WIDTH] != '0, prod_next[2*WIDTH-1:WIDTH] != '0};
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      sh_op_q  <= '0;
      fwe_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      sh_op_q  <= sh_op_d;
      fwe_q    <= fwe_d;
`ifdef ALU_SEQ_MUL_EN
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

  // Branch conditions on the registered {N,Z,V,C}.
  always_comb begin
    case (cond)
      4'd0:    br_taken = 1'b0;
      4'd1:    br_taken = flags_q[2];
      4'd2:    br_taken = !flags_q[2];
      4'd3:    br_taken = flags_q[0];
      4'd4:    br_taken = !flags_q[0];
      4'd5:    br_taken = flags_q[3];
      4'd6:    br_taken = !flags_q[3];
      4'd7:    br_taken = flags_q[1];
      4'd8:    br_taken = !flags_q[1];
      4'd9:    br_taken = flags_q[0] && !flags_q[2];
      4'd10:   br_taken = !flags_q[0] || flags_q[2];
      4'd11:   br_taken = flags_q[3] == flags_q[1];
      4'd12:   br_taken = flags_q[3] != flags_q[1];
      4'd13:   br_taken = !flags_q[2] && (flags_q[3] == flags_q[1]);
      4'd14:   br_taken = flags_q[2] || (flags_q[3] != flags_q[1]);
      default: br_taken = 1'b1;
    endcase
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with a reference model feeding an expected-result queue.
// Multiply expectations follow ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset, start, flag_we, flush;
  logic [3:0]    op, cond;
  logic [W-1:0]  a, b;
  logic          ready, done, err, br_taken;
  logic [W-1:0]  result;
  logic [3:0]    flags;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flag_we(flag_we), .flush(flush), .cond(cond), .ready(ready), .done(done),
    .err(err), .result(result), .flags(flags), .br_taken(br_taken)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mdl_res;
  logic [3:0]   mdl_flg;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         err;
    int           lat;
    int           acc;
    int           opn;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ovf(input longint s);
    return (s > 64'sh0000_0000_7FFF_FFFF) || (s < 64'shFFFF_FFFF_8000_0000);
  endfunction

  function automatic logic br_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'd0: return 1'b0;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return cy;
      4'd4: return !cy;
      4'd5: return n;
      4'd6: return !n;
      4'd7: return v;
      4'd8: return !v;
      4'd9: return cy & !z;
      4'd10: return !cy | z;
      4'd11: return n == v;
      4'd12: return n != v;
      4'd13: return !z & (n == v);
      4'd14: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: updates mdl_res/mdl_flg and returns the expected completion.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic f, output exp_t e);
    longint sx, sy;
    logic [63:0] u;
    logic [W-1:0] r;
    logic v, c, legal, wr, cin;
    int n;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    n = int'(y[4:0]);
    r = '0; v = 1'b0; c = 1'b0; legal = 1'b1; wr = 1'b1; u = '0;
    cin = mdl_flg[0];
    e.lat = 0;
    case (o)
      4'd1: r = x;
      4'd2: r = y;
      4'd3: begin u = {32'b0, x} + {32'b0, y}; r = x + y; c = u[32]; v = ovf(sx + sy); end
      4'd4, 4'd14: begin r = x - y; c = (x >= y); v = ovf(sx - sy); wr = (o == 4'd4); end
      4'd5: r = x | y;
      4'd6: r = x & y;
      4'd7: begin r = x + 1; c = (x == 32'hFFFF_FFFF); v = ovf(sx + 1); end
      4'd8: r = x ^ y;
      4'd9: begin r = x << n; c = (n == 0) ? 1'b0 : x[32-n]; e.lat = n; end
      4'd10: begin r = x >> n; c = (n == 0) ? 1'b0 : x[n-1]; e.lat = n; end
      4'd11: begin r = $signed(x) >>> n; c = (n == 0) ? 1'b0 : x[n-1]; e.lat = n; end
`ifdef ALU_SEQ_MUL_EN
      4'd12: begin
        u = {32'b0, x} * {32'b0, y}; r = u[31:0]; v = (u[63:32] != 0); c = v; e.lat = W;
      end
`else
      4'd12: legal = 1'b0;
`endif
      4'd13: begin
        u = {32'b0, x} + {32'b0, y} + {63'b0, cin}; r = u[31:0]; c = u[32];
        v = ovf(sx + sy + longint'(cin));
      end
      4'd15: legal = 1'b0;
      default: r = '0;
    endcase
    if (!legal) mdl_res = '0;
    else if (wr) mdl_res = r;
    if (legal && f) mdl_flg = {r[31], r == 0, v, c};
    e.res = mdl_res;
    e.flg = mdl_flg;
    e.err = !legal;
  endtask

  // Called #1 after an edge; drives a request across the next edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic f, input bit track);
    exp_t e;
    op = o; a = x; b = y; flag_we = f; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (track) begin
      model(o, x, y, f, e);
      e.acc = cyc;
      e.opn = int'(o);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    exp_t e;
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    if (done !== 1'b1) begin
      check("done_timeout", done, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_done", done, 0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("op%0d_result", e.opn), result, e.res);
    check($sformatf("op%0d_flags", e.opn), flags, e.flg);
    check($sformatf("op%0d_err", e.opn), err, e.err);
    check($sformatf("op%0d_latency", e.opn), cyc - e.acc, e.lat);
    check($sformatf("op%0d_ready_at_done", e.opn), ready, 1);
  endtask

  task automatic br_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1;
      check($sformatf("%s_br%0d", tag, i), br_taken, br_ref(4'(i), mdl_flg));
    end
    @(posedge clock); #1;
  endtask

  typedef struct { logic [3:0] o; logic [W-1:0] x; logic [W-1:0] y; logic f; } stim_t;
  stim_t tbl[$];

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    flag_we = 1'b0; flush = 1'b0; cond = '0;
    mdl_res = '0; mdl_flg = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Signed overflow, then back-to-back issue.
    issue(4'd3, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1);
    wait_done(2);
    check("ovf_flags_const", flags, 4'b1010);
    issue(4'd1, 32'h1234, 32'h0, 1'b0, 1'b1);
    wait_done(2);
    br_sweep("ovf");

    issue(4'd14, 32'd5, 32'd5, 1'b1, 1'b1);
    wait_done(2);
    check("cmp_flags_const", flags, 4'b0101);
    check("cmp_result_kept", result, 32'h1234);
    br_sweep("cmp");

    // Long shift with an ignored start mid-way.
    issue(4'd9, 32'h1, 32'd31, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("shl_busy_ready", ready, 0);
      check("shl_busy_done", done, 0);
      if (i == 2) begin
        op = 4'd1; a = 32'hDEAD; start = 1'b1;
      end
      @(posedge clock); #1;
      start = 1'b0;
    end
    wait_done(40);
    check("shl_result_const", result, 32'h8000_0000);
    @(posedge clock); #1;
    check("shl_done_single", done, 0);

    issue(4'd11, 32'h8000_0000, 32'd4, 1'b1, 1'b1);
    wait_done(10);
    check("asr_result_const", result, 32'hF800_0000);
    check("asr_flags_const", flags, 4'b1000);
    br_sweep("asr");

    tbl = '{
      '{4'd4, 32'd3, 32'd5, 1'b1}, '{4'd13, 32'd7, 32'd8, 1'b1},
      '{4'd7, 32'hFFFF_FFFF, 32'd0, 1'b1}, '{4'd13, 32'd1, 32'd1, 1'b1},
      '{4'd5, 32'hF0, 32'h0F, 1'b1}, '{4'd6, 32'hFF00, 32'h0FF0, 1'b0},
      '{4'd8, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1}, '{4'd2, 32'd0, 32'h8000_0001, 1'b1},
      '{4'd0, 32'd9, 32'd9, 1'b1}, '{4'd9, 32'hA5, 32'd0, 1'b1},
      '{4'd10, 32'h8000_0003, 32'd1, 1'b1}, '{4'd15, 32'd1, 32'd1, 1'b1},
      '{4'd4, 32'h8000_0000, 32'd1, 1'b1}, '{4'd12, 32'd3, 32'd5, 1'b1},
      '{4'd9, 32'hC000_0001, 32'd2, 1'b1}, '{4'd3, 32'hFFFF_FFFF, 32'd2, 1'b0}
    };
    foreach (tbl[i]) begin
      issue(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].f, 1'b1);
      wait_done(40);
    end

    issue(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1);
    wait_done(40);
`ifdef ALU_SEQ_MUL_EN
    check("mul_flags_const", flags, 4'b0111);
`else
    check("mul_illegal_err_const", err, 1);
`endif

    // Flush 10 cycles into a 20-bit shift.
    issue(4'd10, 32'hFFFF_0000, 32'd20, 1'b1, 1'b0);
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_ready", ready, 1);
    check("flush_result", result, mdl_res);
    check("flush_flags", flags, mdl_flg);
    ndone = 0;
    repeat (12) begin
      if (done === 1'b1) ndone++;
      @(posedge clock); #1;
    end
    check("flush_no_done", ndone, 0);

    // Flush on the final iteration edge wins.
    issue(4'd9, 32'h3, 32'd3, 1'b1, 1'b0);
    repeat (2) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_last_done", done, 0);
    check("flush_last_ready", ready, 1);
    check("flush_last_result", result, mdl_res);

    // Flush in IDLE does not block an accept.
    flush = 1'b1;
    issue(4'd2, 32'd0, 32'hCAFE, 1'b1, 1'b1);
    flush = 1'b0;
    wait_done(2);

    // Asynchronous reset mid-operation.
`ifdef ALU_SEQ_MUL_EN
    issue(4'd12, 32'd7, 32'd9, 1'b1, 1'b0);
`else
    issue(4'd10, 32'hFFFF_FFFF, 32'd25, 1'b1, 1'b0);
`endif
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    mdl_res = '0;
    mdl_flg = '0;
    check("arst_ready", ready, 1);
    check("arst_result", result, mdl_res);
    check("arst_flags", flags, mdl_flg);
    check("arst_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1) ndone++;
      @(posedge clock); #1;
    end
    check("arst_no_done", ndone, 0);

    issue(4'd3, 32'd1, 32'd2, 1'b1, 1'b1);
    wait_done(2);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
